// File: rtl/multi_key_flop.sv
// multi_key_flop: per-channel key synchronizer, debouncer and follow/toggle LED driver.
module multi_key_flop #(
  parameter int CH      = 4,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = $clog2(CNT_MAX)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [CH-1:0] key_in,
  input  logic [CH-1:0] mode,
  output logic [CH-1:0] led_out,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_release
);
  for (genvar g = 0; g < CH; g++) begin : gen_ch
    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d, press_q, press_d, rel_q, rel_d;
    logic             diff, done;
    always_comb begin
      diff     = sync_q[1] != stable_q;
      done     = diff && (cnt_q == CNT_W'(CNT_MAX - 1));
      cnt_d    = (diff && !done) ? cnt_q + CNT_W'(1) : '0;
      stable_d = done ? sync_q[1] : stable_q;
      press_d  = done && !sync_q[1];
      rel_d    = done && sync_q[1];
      // mode is used as sampled this edge, so a press coinciding with a mode change obeys the new mode
      led_d    = mode[g] ? (led_q ^ press_d) : ~stable_d;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync_q   <= 2'b11;
        stable_q <= 1'b1;
        cnt_q    <= '0;
        led_q    <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
      end else begin
        sync_q   <= {sync_q[0], key_in[g]};
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        led_q    <= led_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
      end
    end
    assign led_out[g]     = led_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = rel_q;
  end
endmodule
